// File: rtl/mult_pipe_pkg.sv
// Shared definitions for the pipelined multiplier: default widths and an
// exact reference product function usable at any width up to MUL_MAX_W.
package mult_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 2;
  localparam int DEF_TAG_W  = 4;
  localparam int MUL_MAX_W  = 64;

  // Exact 2*width-bit product of the low 'width' bits of a and b.
  // Operands are sign- or zero-extended to the full working width before
  // multiplying, then the result is masked to 2*width bits.
  function automatic logic [2*MUL_MAX_W-1:0] mul_ext(
    input logic [MUL_MAX_W-1:0] a,
    input logic [MUL_MAX_W-1:0] b,
    input logic                 signed_mode,
    input int                   width
  );
    logic [2*MUL_MAX_W-1:0] op_mask;
    logic [2*MUL_MAX_W-1:0] res_mask;
    logic [2*MUL_MAX_W-1:0] ae;
    logic [2*MUL_MAX_W-1:0] be;
    op_mask  = {(2*MUL_MAX_W){1'b1}} >> (2*MUL_MAX_W - width);
    res_mask = {(2*MUL_MAX_W){1'b1}} >> (2*MUL_MAX_W - 2*width);
    ae = {{MUL_MAX_W{1'b0}}, a} & op_mask;
    be = {{MUL_MAX_W{1'b0}}, b} & op_mask;
    if (signed_mode && a[width-1]) ae = ae | ~op_mask;
    if (signed_mode && b[width-1]) be = be | ~op_mask;
    return (ae * be) & res_mask;
  endfunction

endpackage

// File: rtl/mult_pipe_if.sv
// Operand/product stream bundle for mult_pipe.
// Handshake: a beat transfers on a rising edge where valid && ready. The
// sender must not make valid depend on ready; the receiver may make ready
// depend on valid. Payload is only meaningful while valid is high.
interface mult_pipe_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [TAG_W-1:0]   out_tag;

  // Producer/consumer side: drives operands and accepts products.
  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );

endinterface

// File: rtl/mult_pipe_slice.sv
// One pipeline slice: a valid bit plus payload register. On advance it takes
// the upstream valid; payload is only replaced when the upstream beat is
// valid, so an emptied slice keeps its last payload visible.
module mult_pipe_slice #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_adv,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  output logic [PW-1:0] o_data
);

  logic          r_valid;
  logic [PW-1:0] r_data;

  // Load on advance, hold otherwise; async clear of valid and payload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined WIDTHxWIDTH multiplier with per-beat signed/unsigned mode,
// sideband tag and bubble-collapsing valid/ready flow control.
// Slice 1 holds operands (or the product when STAGES==1); the multiplier
// sits between slice 1 and slice 2; later slices forward {product, tag}.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic        clk,
  input  logic        reset,
  mult_pipe_if.slave  bus,
  output logic        busy
);

  localparam int PW_OP = 2*WIDTH + TAG_W + 1;
  localparam int PW_PR = 2*WIDTH + TAG_W;

  logic [STAGES:1]    w_v;
  logic [STAGES:1]    w_adv;
  logic [PW_PR-1:0]   w_d [1:STAGES];
  logic [WIDTH-1:0]   w_mul_a;
  logic [WIDTH-1:0]   w_mul_b;
  logic               w_mul_s;
  logic [2*WIDTH-1:0] w_ax;
  logic [2*WIDTH-1:0] w_bx;
  logic [2*WIDTH-1:0] w_prod;

  // Slice i may advance when it or any slice downstream of it is empty, or
  // the consumer pops: the unrolled form of advance[i] = !v[i] || advance[i+1].
  for (genvar i = 1; i <= STAGES; i++) begin : g_adv
    assign w_adv[i] = bus.out_ready | ~(&w_v[STAGES:i]);
  end

  // Extend to full product width (sign or zero) so the low 2*WIDTH bits of
  // the product are exact in either mode.
  assign w_ax   = {{WIDTH{w_mul_s & w_mul_a[WIDTH-1]}}, w_mul_a};
  assign w_bx   = {{WIDTH{w_mul_s & w_mul_b[WIDTH-1]}}, w_mul_b};
  assign w_prod = w_ax * w_bx;

  if (STAGES == 1) begin : g_s1_prod
    // Single stage: multiply straight from the input and register the product.
    assign w_mul_a = bus.in_a;
    assign w_mul_b = bus.in_b;
    assign w_mul_s = bus.in_signed;

    mult_pipe_slice #(.PW(PW_PR)) u_s1 (
      .clk     (clk),
      .reset   (reset),
      .i_adv   (w_adv[1]),
      .i_valid (bus.in_valid),
      .i_data  ({w_prod, bus.in_tag}),
      .o_valid (w_v[1]),
      .o_data  (w_d[1])
    );
  end else begin : g_s1_op
    logic [PW_OP-1:0] w_s1;

    mult_pipe_slice #(.PW(PW_OP)) u_s1 (
      .clk     (clk),
      .reset   (reset),
      .i_adv   (w_adv[1]),
      .i_valid (bus.in_valid),
      .i_data  ({bus.in_signed, bus.in_tag, bus.in_a, bus.in_b}),
      .o_valid (w_v[1]),
      .o_data  (w_s1)
    );

    assign w_mul_s = w_s1[PW_OP-1];
    assign w_mul_a = w_s1[WIDTH +: WIDTH];
    assign w_mul_b = w_s1[0 +: WIDTH];
    // Payload offered to slice 2: the product and the tag of slice 1.
    assign w_d[1]  = {w_prod, w_s1[2*WIDTH +: TAG_W]};
  end

  for (genvar i = 2; i <= STAGES; i++) begin : g_tail
    mult_pipe_slice #(.PW(PW_PR)) u_s (
      .clk     (clk),
      .reset   (reset),
      .i_adv   (w_adv[i]),
      .i_valid (w_v[i-1]),
      .i_data  (w_d[i-1]),
      .o_valid (w_v[i]),
      .o_data  (w_d[i])
    );
  end

  assign bus.in_ready    = w_adv[1];
  assign bus.out_valid   = w_v[STAGES];
  assign bus.out_product = w_d[STAGES][TAG_W +: 2*WIDTH];
  assign bus.out_tag     = w_d[STAGES][TAG_W-1:0];
  assign busy            = |w_v;

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed 32-bit vectors and sequences on STAGES=2/3
// instances, plus a random 8-bit sweep over STAGES 1, 2 and 4.
module tb_mult_pipe;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rand_go  = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- 32-bit instances ----------------
  logic busy_a;
  logic busy_b;
  mult_pipe_if #(.WIDTH(32), .TAG_W(4)) if_a ();
  mult_pipe_if #(.WIDTH(32), .TAG_W(4)) if_b ();

  mult_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave), .busy(busy_a)
  );
  mult_pipe #(.WIDTH(32), .STAGES(3), .TAG_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.slave), .busy(busy_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs [10];

  // ---------------- 8-bit random sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int SG = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    mult_pipe_if #(.WIDTH(8), .TAG_W(4)) rif ();
    logic rbusy;
    logic done = 1'b0;
    logic [19:0] exp_q[$];

    mult_pipe #(.WIDTH(8), .STAGES(SG), .TAG_W(4)) dut (
      .clk(clk), .reset(reset), .bus(rif.slave), .busy(rbusy)
    );

    initial begin : drive
      logic         holding;
      logic         in_fire;
      logic         out_fire;
      logic         stall_prev;
      logic [19:0]  act;
      logic [19:0]  act_prev;
      logic [19:0]  exp_v;
      logic [19:0]  exp_pop;
      logic [15:0]  hand_p;
      logic [127:0] m;
      int           n_fixed;
      rif.in_valid  = 1'b0;
      rif.out_ready = 1'b1;
      rif.in_a      = '0;
      rif.in_b      = '0;
      rif.in_signed = 1'b0;
      rif.in_tag    = '0;
      holding       = 1'b0;
      stall_prev    = 1'b0;
      act_prev      = '0;
      exp_v         = '0;
      hand_p        = '0;
      n_fixed       = 0;
      wait (rand_go);
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (!holding) begin
          if (n_fixed < 4) begin
            case (n_fixed)
              0:       begin rif.in_a = 8'h80; rif.in_b = 8'h80; rif.in_signed = 1'b1; end
              1:       begin rif.in_a = 8'h80; rif.in_b = 8'h7F; rif.in_signed = 1'b1; end
              2:       begin rif.in_a = 8'h80; rif.in_b = 8'h80; rif.in_signed = 1'b0; end
              default: begin rif.in_a = 8'hFF; rif.in_b = 8'hFF; rif.in_signed = 1'b0; end
            endcase
            rif.in_tag   = 4'(n_fixed + 8);
            rif.in_valid = 1'b1;
          end else begin
            rif.in_a      = 8'($urandom_range(0, 255));
            rif.in_b      = 8'($urandom_range(0, 255));
            rif.in_signed = 1'($urandom_range(0, 1));
            rif.in_tag    = 4'($urandom_range(0, 15));
            rif.in_valid  = ($urandom_range(0, 3) != 0);
          end
        end
        rif.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        in_fire  = rif.in_valid && rif.in_ready;
        out_fire = rif.out_valid && rif.out_ready;
        act      = {rif.out_product, rif.out_tag};
        if (stall_prev) begin
          check($sformatf("rand_s%0d_stall_valid", SG), 128'(rif.out_valid), 128'(1'b1));
          check($sformatf("rand_s%0d_stall_hold", SG), 128'(act), 128'(act_prev));
        end
        stall_prev = rif.out_valid && !rif.out_ready;
        act_prev   = act;
        if (in_fire) begin
          if (n_fixed < 4) begin
            case (n_fixed)
              0:       hand_p = 16'h4000; // -128 * -128 = 16384
              1:       hand_p = 16'hC080; // -128 * 127  = -16256
              2:       hand_p = 16'h4000; // 128 * 128   = 16384
              default: hand_p = 16'hFE01; // 255 * 255   = 65025
            endcase
            exp_v = {hand_p, rif.in_tag};
            n_fixed++;
          end else begin
            m     = mul_ext(64'(rif.in_a), 64'(rif.in_b), rif.in_signed, 8);
            exp_v = {m[15:0], rif.in_tag};
          end
        end
        @(posedge clk);
        if (out_fire) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_s%0d_extra_beat: got 0x%0h, expected no beat", SG, act);
          end else begin
            exp_pop = exp_q.pop_front();
            check($sformatf("rand_s%0d_beat", SG), 128'(act), 128'(exp_pop));
          end
        end
        if (in_fire) exp_q.push_back(exp_v);
        holding = rif.in_valid && !in_fire;
      end
      // Drain whatever is still in flight.
      @(negedge clk);
      rif.in_valid  = 1'b0;
      rif.out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
        if (exp_q.size() == 0) break;
        #1;
        if (rif.out_valid) begin
          exp_pop = exp_q.pop_front();
          check($sformatf("rand_s%0d_drain", SG),
                128'({rif.out_product, rif.out_tag}), 128'(exp_pop));
        end
        @(negedge clk);
      end
      #1;
      check($sformatf("rand_s%0d_left", SG), 128'(exp_q.size()), 128'(0));
      check($sformatf("rand_s%0d_idle_valid", SG), 128'(rif.out_valid), 128'(1'b0));
      check($sformatf("rand_s%0d_idle_busy", SG), 128'(rbusy), 128'(1'b0));
      done = 1'b1;
    end
  end

  // ---------------- directed sequences ----------------
  initial begin : main
    int acc;
    int got;
    logic all_done;
    reset          = 1'b0;
    if_a.in_valid  = 1'b0; if_a.in_a = '0; if_a.in_b = '0;
    if_a.in_signed = 1'b0; if_a.in_tag = '0; if_a.out_ready = 1'b1;
    if_b.in_valid  = 1'b0; if_b.in_a = '0; if_b.in_b = '0;
    if_b.in_signed = 1'b0; if_b.in_tag = '0; if_b.out_ready = 1'b1;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000002, 1'b0, 4'd3,  64'h00000001_FFFFFFFE};
    vecs[1] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 4'd4,  64'hFFFFFFFF_FFFFFFFE};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 4'd5,  64'h40000000_00000000};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 4'd6,  64'h40000000_00000000};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd7,  64'hFFFFFFFE_00000001};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd8,  64'h00000000_00000001};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 4'd9,  64'hC0000000_80000000};
    vecs[7] = '{32'h00003039, 32'h00000000, 1'b0, 4'd10, 64'h00000000_00000000};
    vecs[8] = '{32'h00010000, 32'h00010000, 1'b0, 4'd11, 64'h00000001_00000000};
    vecs[9] = '{32'h00000003, 32'hFFFFFFFB, 1'b1, 4'd12, 64'hFFFFFFFF_FFFFFFF1};

    // Reset held with a valid input pending: nothing may enter.
    if_a.in_valid = 1'b1; if_a.in_a = 32'd5; if_a.in_b = 32'd5; if_a.in_tag = 4'd1;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", 128'(if_a.out_valid), 128'(1'b0));
      check("rst_busy", 128'(busy_a), 128'(1'b0));
      check("rst_product", 128'(if_a.out_product), 128'(0));
      check("rst_tag", 128'(if_a.out_tag), 128'(0));
    end
    reset = 1'b1;
    if_a.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_valid", 128'(if_a.out_valid), 128'(1'b0));
      check("post_rst_product", 128'(if_a.out_product), 128'(0));
      check("post_rst_busy", 128'(busy_a), 128'(1'b0));
    end

    // Single beats: latency of exactly 2 and exact products.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_a.in_a      = vecs[i].a;
      if_a.in_b      = vecs[i].b;
      if_a.in_signed = vecs[i].s;
      if_a.in_tag    = vecs[i].tag;
      if_a.in_valid  = 1'b1;
      #1;
      check($sformatf("vec%0d_in_ready", i), 128'(if_a.in_ready), 128'(1'b1));
      @(negedge clk);
      if_a.in_valid = 1'b0;
      check($sformatf("vec%0d_early_valid", i), 128'(if_a.out_valid), 128'(1'b0));
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 128'(if_a.out_valid), 128'(1'b1));
      check($sformatf("vec%0d_product", i), 128'(if_a.out_product), 128'(vecs[i].prod));
      check($sformatf("vec%0d_tag", i), 128'(if_a.out_tag), 128'(vecs[i].tag));
    end

    // Streaming: 8 back-to-back beats emerge on 8 consecutive cycles.
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 9) begin
        check($sformatf("stream%0d_valid", k - 2), 128'(if_a.out_valid), 128'(1'b1));
        check($sformatf("stream%0d_product", k - 2), 128'(if_a.out_product),
              128'(64'((k - 2) * (k - 1))));
        check($sformatf("stream%0d_tag", k - 2), 128'(if_a.out_tag), 128'(4'(k - 2)));
      end else begin
        check($sformatf("stream_idle%0d_valid", k), 128'(if_a.out_valid), 128'(1'b0));
      end
      if (k < 8) begin
        if_a.in_a      = 32'(k);
        if_a.in_b      = 32'(k + 1);
        if_a.in_signed = 1'b0;
        if_a.in_tag    = 4'(k);
        if_a.in_valid  = 1'b1;
      end else begin
        if_a.in_valid = 1'b0;
      end
    end

    // Backpressure on the 3-stage instance: exactly 3 beats buffered.
    acc = 0;
    if_b.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if_b.in_valid  = 1'b1;
      if_b.in_a      = 32'(100 + acc);
      if_b.in_b      = 32'd3;
      if_b.in_signed = 1'b0;
      if_b.in_tag    = 4'(acc);
      #1;
      if (if_b.out_valid) begin
        check("bp_hold_product", 128'(if_b.out_product), 128'(64'd300));
        check("bp_hold_tag", 128'(if_b.out_tag), 128'(4'd0));
      end
      if (if_b.in_ready) acc++;
    end
    check("bp_in_ready_low", 128'(if_b.in_ready), 128'(1'b0));
    check("bp_accepts", 128'(acc), 128'(3));
    check("bp_out_valid", 128'(if_b.out_valid), 128'(1'b1));
    // Full pipe with pop and accept in the same cycle, then drain.
    @(negedge clk);
    if_b.out_ready = 1'b1;
    if_b.in_valid  = 1'b1;
    if_b.in_a      = 32'(100 + acc);
    if_b.in_tag    = 4'(acc);
    #1;
    check("bp_full_pop_accept", 128'(if_b.in_ready), 128'(1'b1));
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (if_b.out_valid) begin
        check($sformatf("bp_drain%0d_product", got), 128'(if_b.out_product),
              128'(64'(100 + got) * 64'd3));
        check($sformatf("bp_drain%0d_tag", got), 128'(if_b.out_tag), 128'(4'(got)));
        got++;
      end
      @(negedge clk);
      if_b.in_valid = 1'b0;
      #1;
    end
    check("bp_drain_count", 128'(got), 128'(4));

    // Mid-flight reset: two beats in flight, async clear between edges.
    @(negedge clk);
    if_a.in_a = 32'd6; if_a.in_b = 32'd7; if_a.in_signed = 1'b0; if_a.in_tag = 4'd1;
    if_a.in_valid = 1'b1;
    @(negedge clk);
    if_a.in_a = 32'd8; if_a.in_b = 32'd9; if_a.in_tag = 4'd2;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    #1;
    check("mid_pre_valid", 128'(if_a.out_valid), 128'(1'b1));
    check("mid_pre_product", 128'(if_a.out_product), 128'(64'd42));
    check("mid_pre_busy", 128'(busy_a), 128'(1'b1));
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 128'(if_a.out_valid), 128'(1'b0));
    check("mid_rst_busy", 128'(busy_a), 128'(1'b0));
    check("mid_rst_product", 128'(if_a.out_product), 128'(0));
    check("mid_rst_tag", 128'(if_a.out_tag), 128'(0));
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_post_valid", 128'(if_a.out_valid), 128'(1'b0));
      check("mid_post_busy", 128'(busy_a), 128'(1'b0));
    end

    // Random sweep on the 8-bit instances, bounded wait for completion.
    rand_go  = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done;
      if (all_done) break;
      @(negedge clk);
    end
    check("rand_done", 128'({g_rand[0].done, g_rand[1].done, g_rand[2].done}), 128'(3'b111));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
